dmem_write_buffer: RTL

//  Data-memory responder for the single-cycle MIPS core: services the core's store

---
 rtl/dmem_write_buffer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: data-memory responder for the single-cycle MIPS core.
// Stores are queued in a DEPTH-entry write buffer and retired to internal word
// RAM one entry every DRAIN_CYCLES cycles. Loads are combinational and forward
// the newest buffered store to the same word, falling back to RAM otherwise.
// Build option: define WBUF_COALESCE_EN to merge a store into the newest
// buffered entry when both target the same word.
module dmem_write_buffer #(
   parameter int DEPTH        = 4,
   parameter int ADDR_BITS    = 6,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwrite,
   input  logic [31:0]              dataadr,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam int TMR_BITS = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int WORDS    = 1 << ADDR_BITS;

   localparam logic [TMR_BITS-1:0] TMR_RELOAD = TMR_BITS'(DRAIN_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] CNT_FULL   = CNT_BITS'(DEPTH);
   localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
   localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);

   // Word RAM and write-buffer storage (storage is not reset; validity comes
   // from the head/count bookkeeping).
   logic [31:0]           ram       [WORDS];
   logic [ADDR_BITS-1:0]  buf_idx   [DEPTH];
   logic [31:0]           buf_data  [DEPTH];

   // Buffer bookkeeping state.
   logic [PTR_BITS-1:0]   head_reg, head_next;
   logic [PTR_BITS-1:0]   tail_reg, tail_next;
   logic [CNT_BITS-1:0]   count_reg, count_next;
   logic [TMR_BITS-1:0]   timer_reg, timer_next;
   logic                  overflow_reg, overflow_next;

   // Per-cycle decisions.
   logic [ADDR_BITS-1:0]  idx;
   logic                  is_empty;
   logic                  is_full;
   logic                  pop_en;
   logic                  merge_en;
   logic                  accept;
   logic                  push_en;
   logic                  drop_en;

   // Forwarding lookup.
   logic [DEPTH-1:0]      hit;
   logic [31:0]           hit_data  [DEPTH];

   // Byte-offset bits and address bits above the RAM are deliberately ignored,
   // so addresses alias modulo the RAM size.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{dataadr[31:ADDR_BITS+2], dataadr[1:0]};

   assign idx      = dataadr[ADDR_BITS+1:2];
   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == CNT_FULL);

   // The head retires when the buffer is non-empty and its timer has run out.
   assign pop_en   = !is_empty && (timer_reg == '0);

`ifdef WBUF_COALESCE_EN
   logic [PTR_BITS-1:0]   newest_ptr;
   assign newest_ptr = tail_reg - PTR_ONE;

   // Merge into the newest entry unless that entry is the sole one and is
   // leaving this cycle; then the store must allocate a fresh entry.
   assign merge_en = memwrite && !is_empty
                     && (buf_idx[newest_ptr] == idx)
                     && !(pop_en && (count_reg == CNT_ONE));
`else
   assign merge_en = 1'b0;
`endif

   // A freeing pop makes room for a store even when the buffer is full.
   assign accept  = memwrite && !merge_en;
   assign push_en = accept && (!is_full || pop_en);
   assign drop_en = accept && is_full && !pop_en;

   // State register: pointers, occupancy, drain timer and sticky overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         timer_reg    <= TMR_RELOAD;
         overflow_reg <= 1'b0;
      end else begin
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         count_reg    <= count_next;
         timer_reg    <= timer_next;
         overflow_reg <= overflow_next;
      end
   end

   // Next-state logic for the buffer bookkeeping.
   always_comb begin
      head_next     = head_reg;
      tail_next     = tail_reg;
      count_next    = count_reg;
      timer_next    = timer_reg;
      overflow_next = overflow_reg;

      if (push_en) begin
         tail_next = tail_reg + PTR_ONE;
      end
      if (pop_en) begin
         head_next = head_reg + PTR_ONE;
      end

      case ({push_en, pop_en})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase

      if (drop_en) begin
         overflow_next = 1'b1;
      end

      // Timer idles at its reload value while empty, so a store entering an
      // empty buffer waits a full DRAIN_CYCLES before retiring.
      if (is_empty) begin
         timer_next = TMR_RELOAD;
      end else if (timer_reg == '0) begin
         timer_next = TMR_RELOAD;
      end else begin
         timer_next = timer_reg - TMR_BITS'(1);
      end
   end

   // Buffer storage write: allocate at tail, or merge into the newest entry.
   always_ff @(posedge clk) begin
      if (reset && push_en) begin
         buf_idx[tail_reg]  <= idx;
         buf_data[tail_reg] <= writedata;
      end
`ifdef WBUF_COALESCE_EN
      else if (reset && merge_en) begin
         buf_data[newest_ptr] <= writedata;
      end
`endif
   end

   // RAM write of the retiring head entry; visible from RAM the next cycle.
   always_ff @(posedge clk) begin
      if (reset && pop_en) begin
         ram[buf_idx[head_reg]] <= buf_data[head_reg];
      end
   end

   // Per-slot match, ordered oldest (gi = 0) to newest relative to head.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [PTR_BITS-1:0] slot;
         assign slot         = head_reg + PTR_BITS'(gi);
         assign hit[gi]      = (CNT_BITS'(gi) < count_reg) && (buf_idx[slot] == idx);
         assign hit_data[gi] = buf_data[slot];
      end
   endgenerate

   // Load path: the newest matching buffered store wins, else the RAM word.
   always_comb begin
      readdata = ram[idx];
      for (int k = 0; k < DEPTH; k++) begin
         if (hit[k]) begin
            readdata = hit_data[k];
         end
      end
   end

   assign empty    = is_empty;
   assign full     = is_full;
   assign count    = count_reg;
   assign overflow = overflow_reg;

endmodule
